// File: rtl/inst_fetch.sv
// Instruction fetch unit: a three-state FSM (idle, fetch, execute) that owns the PC and the instruction register.
// Latency: each instruction takes at least two cycles, one in fetch and one in execute.
// Backpressure: inst_ready=0 keeps the FSM in fetch with inst_req high; stall=1 keeps the FSM in execute with PC and IR held.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   inst_data/_ready  response from instruction memory (ignored outside fetch)
//   Branch, rs_data   next-PC select and jr/jalr target, sampled when execute completes
//   stall             holds the current instruction in execute
//   inst_req/_addr    fetch request and address (address equals PC)
//   inst_out, OPcode, Fun, inst_valid   instruction register and its decode slices
//   PC_out, PC_plus4  address of the instruction in IR, and that address plus 4 (link value)
//   addr_err          misaligned next-PC flag
//
// Build option: define IF_ALIGN_CHECK_EN to trap misaligned next-PC values in a halt
// state that only reset can leave. Without it, the low two bits of next-PC are cleared
// and addr_err stays 0.
module inst_fetch (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst_data,
   input  logic        inst_ready,
   input  logic [1:0]  Branch,
   input  logic [31:0] rs_data,
   input  logic        stall,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   output logic [31:0] inst_out,
   output logic [5:0]  OPcode,
   output logic [5:0]  Fun,
   output logic        inst_valid,
   output logic [31:0] PC_out,
   output logic [31:0] PC_plus4,
   output logic        addr_err
);

`ifdef IF_ALIGN_CHECK_EN
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;
`endif

   localparam logic [1:0] BR_SEQ  = 2'b00;
   localparam logic [1:0] BR_COND = 2'b01;
   localparam logic [1:0] BR_JUMP = 2'b10;
   localparam logic [1:0] BR_REG  = 2'b11;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;        // fetch address
   logic [31:0] ir_q, ir_d;        // instruction register
   logic [31:0] ir_pc_q, ir_pc_d;  // address the IR contents were fetched from

   logic [31:0] pc_plus4;
   logic [31:0] br_offset;
   logic [31:0] next_raw;
   logic [31:0] next_pc;

   // ------------------------------------------------------------------
   // Next-PC computation. In execute, pc_q and ir_pc_q are equal, so all
   // targets are formed relative to the instruction currently in IR.
   // ------------------------------------------------------------------
   assign pc_plus4  = ir_pc_q + 32'd4;               // wraps modulo 2^32
   assign br_offset = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

   always_comb begin
      next_raw = pc_plus4;
      case (Branch)
         BR_SEQ:  next_raw = pc_plus4;
         BR_COND: next_raw = pc_plus4 + br_offset;
         BR_JUMP: next_raw = {pc_plus4[31:28], ir_q[25:0], 2'b00};
         BR_REG:  next_raw = rs_data;
         default: next_raw = pc_plus4;
      endcase
   end

`ifdef IF_ALIGN_CHECK_EN
   logic addr_err_q, addr_err_d;
   logic misaligned;

   assign next_pc    = next_raw;
   assign misaligned = |next_raw[1:0];
`else
   // Only jr/jalr can produce a misaligned target; clear the low bits.
   assign next_pc = next_raw & ~32'd3;
`endif

   // ------------------------------------------------------------------
   // FSM next-state and datapath update
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
`ifdef IF_ALIGN_CHECK_EN
      addr_err_d = addr_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (inst_ready) begin
               ir_d    = inst_data;
               ir_pc_d = pc_q;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            // Branch and rs_data matter only on the cycle execute completes.
            if (!stall) begin
`ifdef IF_ALIGN_CHECK_EN
               if (misaligned) begin
                  addr_err_d = 1'b1;
                  state_d    = S_HALT;
               end else begin
                  pc_d    = next_pc;
                  state_d = S_FETCH;
               end
`else
               pc_d    = next_pc;
               state_d = S_FETCH;
`endif
            end
         end
`ifdef IF_ALIGN_CHECK_EN
         S_HALT: begin
            state_d = S_HALT;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= 32'd0;
         ir_q    <= 32'd0;
         ir_pc_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ir_pc_q <= ir_pc_d;
      end
   end

`ifdef IF_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= addr_err_d;
      end
   end

   assign addr_err = addr_err_q;
`else
   assign addr_err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Outputs. inst_req and inst_valid decode the registered state, so an
   // asynchronous reset clears them in the same cycle.
   // ------------------------------------------------------------------
   assign inst_req   = (state_q == S_FETCH);
   assign inst_valid = (state_q == S_EXEC);
   assign inst_addr  = pc_q;
   assign inst_out   = ir_q;
   assign OPcode     = ir_q[31:26];
   assign Fun        = ir_q[5:0];
   assign PC_out     = ir_pc_q;
   assign PC_plus4   = pc_plus4;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, beq, jal, jr, wait states, stall,
// PC wrap, reset during fetch, and the misaligned jr target in both build options.
module tb_inst_fetch;

   logic        clk;
   logic        rst_n;
   logic [31:0] inst_data;
   logic        inst_ready;
   logic [1:0]  Branch;
   logic [31:0] rs_data;
   logic        stall;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_out;
   logic [5:0]  OPcode;
   logic [5:0]  Fun;
   logic        inst_valid;
   logic [31:0] PC_out;
   logic [31:0] PC_plus4;
   logic        addr_err;

   int n_checks = 0;
   int n_errors = 0;

   inst_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst_data  (inst_data),
      .inst_ready (inst_ready),
      .Branch     (Branch),
      .rs_data    (rs_data),
      .stall      (stall),
      .inst_req   (inst_req),
      .inst_addr  (inst_addr),
      .inst_out   (inst_out),
      .OPcode     (OPcode),
      .Fun        (Fun),
      .inst_valid (inst_valid),
      .PC_out     (PC_out),
      .PC_plus4   (PC_plus4),
      .addr_err   (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      inst_data  = 32'd0;
      inst_ready = 1'b0;
      Branch     = 2'b00;
      rs_data    = 32'd0;
      stall      = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_req",   {31'd0, inst_req},   32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_ir",    inst_out,            32'd0);
      chk("rst_addr",  inst_addr,           32'd0);
      chk("rst_pcout", PC_out,              32'd0);
      chk("rst_err",   {31'd0, addr_err},   32'd0);

      // Release: one idle cycle with no request
      rst_n      = 1'b1;
      inst_ready = 1'b1;
      chk("idle_req", {31'd0, inst_req}, 32'd0);
      tick();

      // Sequential fetch 0,4,8,C with instruction valid every second cycle
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("seq_req_%0d", k),   {31'd0, inst_req},   32'd1);
         chk($sformatf("seq_addr_%0d", k),  inst_addr,           32'(4 * k));
         chk($sformatf("seq_valid0_%0d", k), {31'd0, inst_valid}, 32'd0);
         tick();
         chk($sformatf("seq_valid1_%0d", k), {31'd0, inst_valid}, 32'd1);
         chk($sformatf("seq_req0_%0d", k),  {31'd0, inst_req},   32'd0);
         chk($sformatf("seq_pcout_%0d", k), PC_out,              32'(4 * k));
         tick();
      end

      // beq with imm=-1 at 0x10 branches back to itself
      chk("beq_fetch_addr", inst_addr, 32'h0000_0010);
      inst_data = 32'h1000_FFFF;
      tick();
      chk("beq_ir",     inst_out,          32'h1000_FFFF);
      chk("beq_opcode", {26'd0, OPcode},   32'h0000_0004);
      chk("beq_fun",    {26'd0, Fun},      32'h0000_003F);
      Branch = 2'b01;
      tick();
      chk("beq_target", inst_addr, 32'h0000_0010);

      // jr to 0x4000_0000
      inst_data = 32'd0;
      tick();
      Branch  = 2'b11;
      rs_data = 32'h4000_0000;
      tick();
      chk("jr_target", inst_addr, 32'h4000_0000);

      // jal at 0x4000_0000
      Branch    = 2'b00;
      inst_data = 32'h0C00_0040;
      tick();
      chk("jal_pcout",  PC_out,          32'h4000_0000);
      chk("jal_plus4",  PC_plus4,        32'h4000_0004);
      chk("jal_opcode", {26'd0, OPcode}, 32'h0000_0003);
      Branch = 2'b10;
      tick();
      chk("jal_target", inst_addr, 32'h4000_0100);

      // Three wait cycles, then a response: inst_req held four cycles, IR loads once
      Branch     = 2'b00;
      inst_ready = 1'b0;
      inst_data  = 32'hDEAD_BEEF;
      for (int w = 0; w < 3; w++) begin
         chk($sformatf("wait_req_%0d", w), {31'd0, inst_req}, 32'd1);
         chk($sformatf("wait_ir_%0d", w),  inst_out,          32'h0C00_0040);
         tick();
      end
      chk("wait_req_3", {31'd0, inst_req}, 32'd1);
      inst_ready = 1'b1;
      inst_data  = 32'h0000_0020;
      tick();
      chk("wait_ir_loaded", inst_out,          32'h0000_0020);
      chk("wait_fun",       {26'd0, Fun},      32'h0000_0020);
      chk("wait_req_drop",  {31'd0, inst_req}, 32'd0);

      // Stall two cycles: valid held three cycles, PC unchanged, junk select ignored
      stall      = 1'b1;
      Branch     = 2'b11;
      rs_data    = 32'hFFFF_FFF0;
      inst_data  = 32'h1111_1111;
      for (int s = 0; s < 2; s++) begin
         tick();
         chk($sformatf("stall_valid_%0d", s), {31'd0, inst_valid}, 32'd1);
         chk($sformatf("stall_addr_%0d", s),  inst_addr,           32'h4000_0100);
         chk($sformatf("stall_ir_%0d", s),    inst_out,            32'h0000_0020);
      end
      stall  = 1'b0;
      Branch = 2'b00;
      tick();
      chk("stall_release_addr",  inst_addr,           32'h4000_0104);
      chk("stall_release_valid", {31'd0, inst_valid}, 32'd0);

      // PC wrap: 0xFFFF_FFFC + 4 = 0
      tick();
      Branch  = 2'b11;
      rs_data = 32'hFFFF_FFFC;
      tick();
      chk("wrap_fetch_addr", inst_addr, 32'hFFFF_FFFC);
      Branch = 2'b00;
      tick();
      chk("wrap_plus4", PC_plus4, 32'h0000_0000);
      tick();
      chk("wrap_addr", inst_addr, 32'h0000_0000);

      // Reset during fetch: request drops at once, late ready ignored
      chk("midrst_req_before", {31'd0, inst_req}, 32'd1);
      inst_ready = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk("midrst_req",   {31'd0, inst_req},   32'd0);
      chk("midrst_ir",    inst_out,            32'd0);
      chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
      inst_ready = 1'b1;
      inst_data  = 32'h1234_5678;
      tick();
      chk("midrst_late_ready_ir", inst_out, 32'd0);
      rst_n     = 1'b1;
      inst_data = 32'd0;
      chk("midrst_idle_req", {31'd0, inst_req}, 32'd0);
      tick();
      chk("midrst_refetch_req",  {31'd0, inst_req}, 32'd1);
      chk("midrst_refetch_addr", inst_addr,         32'd0);

      // jr to misaligned 0x102
      tick();
      chk("mis_exec_err", {31'd0, addr_err}, 32'd0);
      Branch  = 2'b11;
      rs_data = 32'h0000_0102;
      tick();
`ifdef IF_ALIGN_CHECK_EN
      chk("mis_err",   {31'd0, addr_err},   32'd1);
      chk("mis_req",   {31'd0, inst_req},   32'd0);
      chk("mis_valid", {31'd0, inst_valid}, 32'd0);
      chk("mis_addr",  inst_addr,           32'd0);
      Branch = 2'b00;
      tick();
      tick();
      chk("halt_err",  {31'd0, addr_err},   32'd1);
      chk("halt_req",  {31'd0, inst_req},   32'd0);
      chk("halt_addr", inst_addr,           32'd0);
`else
      chk("mis_addr", inst_addr,           32'h0000_0100);
      chk("mis_err",  {31'd0, addr_err},   32'd0);
      chk("mis_req",  {31'd0, inst_req},   32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 inst_data  input  32  instruction word returned by instruction memory.
REQ-004 inst_ready  input  1  memory handshake; inst_data valid when high during fetch.
REQ-005 Branch  input  2  next-PC select from control decode: 00 seq, 01 taken branch, 10 jump/jal, 11 jr/jalr.
REQ-006 rs_data  input  32  register rs value, target for Branch=11.
REQ-007 stall  input  1  hold current instruction in execute; PC not advanced.
REQ-008 inst_req  output  1  fetch request to instruction memory.
REQ-009 inst_addr  output  32  fetch address, equals PC.
REQ-010 inst_out  output  32  instruction register (IR).
REQ-011 OPcode  output  6  IR[31:26], to control decode.
REQ-012 Fun  output  6  IR[5:0], to control decode.
REQ-013 inst_valid  output  1  IR holds a decodable instruction this cycle.
REQ-014 PC_out  output  32  address of instruction in IR.
REQ-015 PC_plus4  output  32  PC_out+4, link value for jal/jalr.
REQ-016 addr_err  output  1  misaligned next-PC flag (present only with IF_ALIGN_CHECK_EN).

Function
REQ-017 FSM states SHALL be S_IDLE, S_FETCH, S_EXEC, plus S_HALT when IF_ALIGN_CHECK_EN is defined.
REQ-018 S_IDLE SHALL last exactly one cycle after reset release, inst_req=0, then go to S_FETCH.
REQ-019 S_FETCH SHALL drive inst_req=1 and inst_addr=PC, remaining in S_FETCH while inst_ready=0.
REQ-020 On inst_ready=1 in S_FETCH, IR SHALL capture inst_data at that edge and FSM SHALL enter S_EXEC; inst_req drops the next cycle.
REQ-021 inst_valid SHALL be 1 only in S_EXEC; OPcode/Fun SHALL be combinational slices of IR.
REQ-022 In S_EXEC with stall=0, PC SHALL load next_pc and FSM SHALL return to S_FETCH; minimum throughput one instruction per two cycles.
REQ-023 In S_EXEC with stall=1, FSM, PC and IR SHALL hold; Branch/rs_data SHALL be sampled only on the cycle stall falls to 0.
REQ-024 next_pc: Branch=00 -> PC+4; 01 -> PC+4+{sext(IR[15:0]),2'b00}; 10 -> {PC_plus4[31:28],IR[25:0],2'b00}; 11 -> rs_data.
REQ-025 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-026 inst_ready outside S_FETCH SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force S_IDLE, PC=0, IR=0, inst_req=0, inst_valid=0, addr_err=0, regardless of edge.
REQ-028 Reset asserted mid-fetch SHALL abandon the request; a late inst_ready SHALL not update IR.
REQ-029 After release, first fetch address SHALL be 32'h0000_0000.

Configuration
REQ-030 Macro IF_ALIGN_CHECK_EN SHALL gate misaligned-target checking.
REQ-031 Defined: next_pc[1:0]!=0 in S_EXEC SHALL set addr_err=1, leave PC unchanged, enter S_HALT; S_HALT exits only by reset.
REQ-032 Undefined: next_pc[1:0] SHALL be forced to 00, addr_err SHALL be tied 0, S_HALT absent.

Verification
REQ-033 Reset release, inst_ready=1 constant, Branch=00 -> inst_addr 0,4,8,C on successive fetches, inst_valid every second cycle.
REQ-034 IR=32'h1000_FFFF (beq, imm=-1) at PC=0x10, Branch=01 -> next inst_addr=0x10.
REQ-035 IR=32'h0C00_0040 (jal) at PC=0x4000_0000, Branch=10 -> inst_addr=0x4000_0100, PC_plus4=0x4000_0004 during EXEC.
REQ-036 inst_ready low 3 cycles then high -> inst_req held 4 cycles, IR updates once; stall=1 for 2 cycles -> inst_valid held 3 cycles, PC unchanged.
REQ-037 rst_n pulsed low while inst_req=1 -> inst_req=0 same cycle, IR=0, next fetch at 0.
REQ-038 Branch=11, rs_data=0x0000_0102: with IF_ALIGN_CHECK_EN addr_err=1, FSM in S_HALT; without it inst_addr=0x0000_0100.
